// File: rtl/usb3_pkt_pkg.sv
// usb3_pkt_pkg: shared header layout, magic byte and packetizer FSM encoding
package usb3_pkt_pkg;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int MAGIC_LSB = 24;
  localparam int SEQ_LSB = 16;
  localparam int SEQ_W = 8;
  localparam int LEN_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_CRC} pkt_state_e;
  function automatic logic [31:0] mk_hdr(input logic [SEQ_W-1:0] seq, input logic [LEN_W-1:0] len);
    return (32'(HDR_MAGIC) << MAGIC_LSB) | (32'(seq) << SEQ_LSB) | 32'(len);
  endfunction
endpackage

// File: rtl/usb3_tx_packetizer_if.sv
// usb3_tx_packetizer_if: sample input and framed-word output handshakes of the packetizer
interface usb3_tx_packetizer_if;
  logic [31:0] in_data, out_data;
  logic in_valid, in_ready, out_valid, out_ready, out_last, out_short;
  modport slave (input in_data, in_valid, out_ready,
                 output in_ready, out_data, out_valid, out_last, out_short);
  modport master (output in_data, in_valid, out_ready,
                  input in_ready, out_data, out_valid, out_last, out_short);
endinterface

// File: rtl/usb3_sync_fifo.sv
// usb3_sync_fifo: single-clock first-word-fall-through FIFO with fill count
module usb3_sync_fifo #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic [AW:0]   fill
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  assign fill = wr_ptr_q - rd_ptr_q;
  assign full = fill[AW];
  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/usb3_tx_packetizer.sv
// usb3_tx_packetizer: frames buffered words into header+payload packets, short-flushed on idle timeout;
// USB3_PKT_CRC_EN appends a 32-bit additive checksum trailer
module usb3_tx_packetizer
  import usb3_pkt_pkg::*;
#(
  parameter int FIFO_AW   = 10,
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 res,
  usb3_tx_packetizer_if.slave  bus,
  output logic [SEQ_W-1:0]     seq_no,
  output logic                 ovf
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [FIFO_AW:0] FULL_PKT = (FIFO_AW+1)'(PKT_WORDS);
  pkt_state_e state_q, state_d;
  logic [31:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, out_short_q, out_short_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic ovf_q, ovf_d, in_rdy_q;
  logic push, pop, full, full_go, short_go, done;
  logic [31:0] rd_data;
  logic [FIFO_AW:0] fill;
`ifdef USB3_PKT_CRC_EN
  logic [31:0] csum_q, csum_d;
`endif
  assign bus.in_ready = in_rdy_q && !full;
  assign push = bus.in_valid && bus.in_ready;
  assign full_go = fill >= FULL_PKT;
  assign short_go = fill != '0 && timer_q == TW'(TIMEOUT - 1);
  assign ovf_d = ovf_q || (bus.in_valid && full);
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last = out_last_q;
  assign bus.out_short = out_short_q;
  assign seq_no = seq_q;
  assign ovf = ovf_q;
  usb3_sync_fifo #(.AW(FIFO_AW), .DW(32)) u_fifo (
    .clk     (clk),
    .rst     (res),
    .wr_en   (push),
    .wr_data (bus.in_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .fill    (fill)
  );
  // State names the word held in the output register; rem counts payload words still to load.
  always_comb begin
    state_d = state_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    out_short_d = out_short_q;
    seq_d = seq_q;
    rem_d = rem_q;
    pop = 1'b0;
    done = 1'b0;
`ifdef USB3_PKT_CRC_EN
    csum_d = csum_q;
`endif
    case (state_q)
      S_IDLE: if (full_go || short_go) begin
        rem_d = full_go ? LEN_W'(PKT_WORDS) : LEN_W'(fill);
        out_data_d = mk_hdr(seq_q, rem_d);
        out_valid_d = 1'b1;
        out_last_d = 1'b0;
        out_short_d = !full_go;
        state_d = S_HDR;
`ifdef USB3_PKT_CRC_EN
        csum_d = out_data_d;
`endif
      end
      S_HDR, S_BODY: if (bus.out_ready) begin
        if (state_q == S_BODY && rem_q == '0) begin
`ifdef USB3_PKT_CRC_EN
          out_data_d = csum_q;
          out_last_d = 1'b1;
          state_d = S_CRC;
`else
          done = 1'b1;
`endif
        end else begin
          pop = 1'b1;
          out_data_d = rd_data;
          rem_d = rem_q - 1'b1;
          state_d = S_BODY;
`ifdef USB3_PKT_CRC_EN
          csum_d = csum_q + rd_data;
`else
          out_last_d = rem_q == LEN_W'(1);
`endif
        end
      end
      S_CRC: done = bus.out_ready;
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      out_valid_d = 1'b0;
      out_last_d = 1'b0;
      out_short_d = 1'b0;
      seq_d = seq_q + 1'b1;
      state_d = S_IDLE;
    end
    timer_d = (push || state_q != S_IDLE || state_d != S_IDLE || fill == '0 || full_go) ? '0 : timer_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_short_q <= 1'b0;
      seq_q <= '0;
      rem_q <= '0;
      timer_q <= '0;
      ovf_q <= 1'b0;
      in_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_short_q <= out_short_d;
      seq_q <= seq_d;
      rem_q <= rem_d;
      timer_q <= timer_d;
      ovf_q <= ovf_d;
      in_rdy_q <= 1'b1;
    end
  end
`ifdef USB3_PKT_CRC_EN
  always_ff @(posedge clk) begin
    if (res) csum_q <= '0;
    else csum_q <= csum_d;
  end
`endif
endmodule

// File: tb/tb_usb3_tx_packetizer.sv
// tb_usb3_tx_packetizer: table-driven packets plus overflow and mid-packet reset sequences,
// checked against a word-level scoreboard
module tb_usb3_tx_packetizer;
  localparam int TIMEOUT = 4096;
  typedef struct {
    int          n;
    logic [31:0] base;
    bit          tog;
    logic [31:0] hdr;
    bit          shrt;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        s;
  } exp_t;
  logic clk, res, tog;
  logic [7:0] seq_no;
  logic ovf;
  int checks = 0, passes = 0;
  vec_t vecs[6];
  exp_t exp_q[$];
  logic [31:0] mdl[$];
  logic stall_q = 1'b0;
  logic [31:0] held_d;
  logic held_l;
  usb3_tx_packetizer_if bus ();
  usb3_tx_packetizer #(.FIFO_AW(10), .PKT_WORDS(256), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .res    (res),
    .bus    (bus),
    .seq_no (seq_no),
    .ovf    (ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (tog) bus.out_ready = !bus.out_ready;
  endtask
  task automatic send(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = base + i;
      mdl.push_back(base + i);
      step();
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic expect_pkt(input logic [31:0] hdr, input logic shrt);
    logic [31:0] sum, w;
    int len;
    bit crc;
`ifdef USB3_PKT_CRC_EN
    crc = 1'b1;
`else
    crc = 1'b0;
`endif
    len = int'(hdr & 32'hFFFF);
    sum = hdr;
    exp_q.push_back('{hdr, 1'b0, shrt});
    for (int i = 0; i < len; i++) begin
      w = mdl.pop_front();
      sum = sum + w;
      exp_q.push_back('{w, (i == len - 1) && !crc, shrt});
    end
    if (crc) exp_q.push_back('{sum, 1'b1, shrt});
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_words_left", 32'(exp_q.size()), 32'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (res) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        checks++;
        if (bus.out_valid && bus.out_data === held_d && bus.out_last === held_l) passes++;
        else $display("FAIL hold: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                      bus.out_valid, bus.out_data, bus.out_last, held_d, held_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL word: got unexpected %h, expected none", bus.out_data);
        else begin
          e = exp_q.pop_front();
          if (bus.out_data === e.d && bus.out_last === e.l && bus.out_short === e.s) passes++;
          else $display("FAIL word: got d=%h l=%b s=%b, expected d=%h l=%b s=%b",
                        bus.out_data, bus.out_last, bus.out_short, e.d, e.l, e.s);
        end
      end
      stall_q = bus.out_valid && !bus.out_ready;
      held_d = bus.out_data;
      held_l = bus.out_last;
    end
  end
  initial begin
    vecs[0] = '{256, 32'h0000_0000, 1'b0, 32'hA500_0100, 1'b0};
    vecs[1] = '{10,  32'h0000_0064, 1'b0, 32'hA501_000A, 1'b1};
    vecs[2] = '{256, 32'h0000_1000, 1'b1, 32'hA502_0100, 1'b0};
    vecs[3] = '{1,   32'hDEAD_BEEF, 1'b0, 32'hA503_0001, 1'b1};
    vecs[4] = '{4,   32'h0000_0001, 1'b0, 32'hA504_0004, 1'b1};
    vecs[5] = '{255, 32'h0000_0007, 1'b1, 32'hA505_00FF, 1'b1};
    res = 1'b1;
    tog = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_seq_no", 32'(seq_no), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    step();
    res = 1'b0;
    step();
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    for (int v = 0; v < 6; v++) begin
      bus.out_ready = 1'b1;
      tog = vecs[v].tog;
      send(vecs[v].n, vecs[v].base);
      expect_pkt(vecs[v].hdr, vecs[v].shrt);
      if (vecs[v].shrt) begin
        repeat (TIMEOUT - 200) step();
        chk("no_early_flush", 32'(bus.out_valid), 32'd0);
      end
      drain(TIMEOUT + 1000);
      tog = 1'b0;
      chk("seq_after_pkt", 32'(seq_no), 32'(v + 1));
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'h7000_0000 + i;
      if (i == 1023) chk("in_ready_1023", 32'(bus.in_ready), 32'd1);
      if (i == 1024) begin
        chk("in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("ovf_before_drop", 32'(ovf), 32'd0);
      end
      if (i < 1024) mdl.push_back(32'h7000_0000 + i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int p = 0; p < 4; p++) expect_pkt({8'hA5, 8'(6 + p), 16'h0100}, 1'b0);
    bus.out_ready = 1'b1;
    drain(8000);
    chk("seq_after_ovf", 32'(seq_no), 32'd10);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    send(256, 32'h9000_0000);
    expect_pkt(32'hA50A_0100, 1'b0);
    repeat (40) step();
    res = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_seq_no", 32'(seq_no), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    mdl.delete();
    step();
    res = 1'b0;
    step();
    send(5, 32'h0000_00B0);
    expect_pkt(32'hA500_0005, 1'b1);
    drain(TIMEOUT + 1000);
    chk("seq_after_rst_pkt", 32'(seq_no), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
